// File: rtl/memory_access_if.sv
// Data-memory bus between the M stage and data memory: request/ready handshake
// with a single outstanding access.
interface memory_access_if #(
    parameter int WIDTH = 32
);
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ready;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// RV32I memory stage: drives the data bus, stalls on wait states, registers
// MEM/WB, and reports misaligned or timed-out accesses on a sticky error flag.
module memory_access #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             ResultSrcM,
    input  logic             MemwriteM,
    input  logic [WIDTH-1:0] ALUresultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCplus4M,
    input  logic [4:0]       RdM,
    memory_access_if.master  dmem,
    output logic             stallM,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [WIDTH-1:0] ALUresultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCplus4W,
    output logic [4:0]       RdW,
    output logic             bus_err
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} stateType;

    stateType         state, nextState;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             latchWe;
    logic [WIDTH-1:0] latchAddr, latchWdata;

    logic             access, misaligned;
    logic             reqC, weC, stallC;
    logic [WIDTH-1:0] addrC, wdataC;
    logic             complete, capture, retire, setErr;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        access      = MemwriteM | ResultSrcM;
        misaligned  = access & (ALUresultM[1:0] != 2'b00);
        nextState   = state;
        waitCntNext = waitCnt;
        reqC        = 1'b0;
        weC         = 1'b0;
        addrC       = '0;
        wdataC      = '0;
        stallC      = 1'b0;
        complete    = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        setErr      = 1'b0;

        unique case (state)
            IDLE: begin
                if (misaligned) begin
                    setErr = 1'b1;
                end else if (access) begin
                    reqC   = 1'b1;
                    weC    = MemwriteM;
                    addrC  = ALUresultM;
                    wdataC = WriteDataM;
                    if (dmem.dmem_ready) begin
                        complete = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        stallC      = 1'b1;
                        capture     = 1'b1;
                        waitCntNext = CNT_W'(1);
                        nextState   = BUSY;
                    end
                end else begin
                    retire = 1'b1;
                end
            end
            BUSY: begin
                reqC   = 1'b1;
                weC    = latchWe;
                addrC  = latchAddr;
                wdataC = latchWdata;
                if (dmem.dmem_ready) begin
                    complete    = 1'b1;
                    retire      = 1'b1;
                    waitCntNext = '0;
                    nextState   = IDLE;
                end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    // Give up: the instruction leaves as a bubble and the pipeline resumes.
                    setErr      = 1'b1;
                    waitCntNext = '0;
                    nextState   = IDLE;
                end else begin
                    stallC      = 1'b1;
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Reset must silence the bus and release the stall at once, even mid-cycle.
    assign dmem.dmem_req   = reqC & rst;
    assign dmem.dmem_we    = weC;
    assign dmem.dmem_addr  = addrC;
    assign dmem.dmem_wdata = wdataC;
    assign stallM          = stallC & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            latchWe    <= 1'b0;
            latchAddr  <= '0;
            latchWdata <= '0;
            bus_err    <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUresultW <= '0;
            ReadDataW  <= '0;
            PCplus4W   <= '0;
            RdW        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= nextState;
            waitCnt <= waitCntNext;
            if (capture) begin
                latchWe    <= MemwriteM;
                latchAddr  <= ALUresultM;
                latchWdata <= WriteDataM;
            end
            if (setErr) begin
                bus_err <= 1'b1;
            end
            if (retire) begin
                RegWriteW  <= RegWriteM & ~MemwriteM;
                ResultSrcW <= ResultSrcM;
                ALUresultW <= ALUresultM;
                PCplus4W   <= PCplus4M;
                RdW        <= RdM;
                ReadDataW  <= (complete & ~MemwriteM) ? dmem.dmem_rdata : '0;
            end else begin
                // Bubble: kill the write, keep the data fields.
                RegWriteW <= 1'b0;
                RdW       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected MEM/WB contents are queued at issue
// and popped on the cycle the instruction leaves the M stage.
module tb_memory_access;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM = 1'b0, ResultSrcM = 1'b0, MemwriteM = 1'b0;
    logic [31:0] ALUresultM = '0, WriteDataM = '0, PCplus4M = '0;
    logic [4:0]  RdM = '0;
    logic        stallM, RegWriteW, ResultSrcW, bus_err;
    logic [31:0] ALUresultW, ReadDataW, PCplus4W;
    logic [4:0]  RdW;

    memory_access_if #(.WIDTH(WIDTH)) bus ();

    memory_access #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemwriteM  (MemwriteM),
        .ALUresultM (ALUresultM),
        .WriteDataM (WriteDataM),
        .PCplus4M   (PCplus4M),
        .RdM        (RdM),
        .dmem       (bus),
        .stallM     (stallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUresultW (ALUresultW),
        .ReadDataW  (ReadDataW),
        .PCplus4W   (PCplus4W),
        .RdW        (RdW),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bubble;
        logic        regWrite;
        logic        resultSrc;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        chkRead;
        logic [31:0] readData;
    } expT;

    expT sb[$];
    int  passCnt  = 0;
    int  checkCnt = 0;

    // Issue one instruction, play memory (ready on cycle readyAt, -1 = never), and
    // compare MEM/WB every cycle until the instruction leaves M.
    task automatic runInstr(input string name, input logic rw, input logic rs, input logic mw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                            input logic [4:0] rd, input int readyAt, input logic [31:0] rdata,
                            output int stalls, output int reqs, output logic stable,
                            output logic [31:0] firstAddr, output logic firstWe,
                            output logic [31:0] firstWdata);
        expT  e, got;
        logic acc, mis, st, done;
        acc   = mw | rs;
        mis   = acc && (alu[1:0] != 2'b00);
        e.bubble    = mis || (acc && (readyAt < 0 || readyAt >= TIMEOUT));
        e.regWrite  = e.bubble ? 1'b0 : (rw & ~mw);
        e.resultSrc = rs;
        e.alu       = alu;
        e.pc        = pc;
        e.rd        = rd;
        e.chkRead   = acc && !e.bubble;
        e.readData  = mw ? 32'h0 : rdata;
        sb.push_back(e);

        RegWriteM = rw; ResultSrcM = rs; MemwriteM = mw;
        ALUresultM = alu; WriteDataM = wd; PCplus4M = pc; RdM = rd;
        stalls = 0; reqs = 0; stable = 1'b1; done = 1'b0;
        firstAddr = '0; firstWe = 1'b0; firstWdata = '0;

        for (int k = 0; k < 40 && !done; k++) begin
            bus.dmem_ready = acc && (readyAt >= 0) && (k == readyAt);
            bus.dmem_rdata = bus.dmem_ready ? rdata : 32'($urandom);
            @(negedge clk);
            st = stallM;
            if (bus.dmem_req) begin
                if (reqs == 0) begin
                    firstAddr = bus.dmem_addr; firstWe = bus.dmem_we; firstWdata = bus.dmem_wdata;
                end else if (bus.dmem_addr !== firstAddr || bus.dmem_we !== firstWe ||
                             bus.dmem_wdata !== firstWdata) begin
                    stable = 1'b0;
                end
                reqs++;
            end
            if (st === 1'b1) stalls++;
            @(posedge clk);
            #1;
            if (st === 1'b1) begin
                checkCnt++;
                if (RegWriteW !== 1'b0 || RdW !== 5'd0)
                    $display("FAIL %s stall bubble: RegWriteW=%b RdW=%0d, required 0/0", name, RegWriteW, RdW);
                else passCnt++;
            end else begin
                got = sb.pop_front();
                done = 1'b1;
                checkCnt++;
                if (got.bubble) begin
                    if (RegWriteW !== 1'b0)
                        $display("FAIL %s retire bubble: RegWriteW=%b, required 0", name, RegWriteW);
                    else passCnt++;
                end else begin
                    if ({RegWriteW, ResultSrcW, ALUresultW, PCplus4W, RdW} !==
                        {got.regWrite, got.resultSrc, got.alu, got.pc, got.rd})
                        $display("FAIL %s W regs: rw=%b rs=%b alu=%h pc=%h rd=%0d, required rw=%b rs=%b alu=%h pc=%h rd=%0d",
                                 name, RegWriteW, ResultSrcW, ALUresultW, PCplus4W, RdW,
                                 got.regWrite, got.resultSrc, got.alu, got.pc, got.rd);
                    else passCnt++;
                    if (got.chkRead) begin
                        checkCnt++;
                        if (ReadDataW !== got.readData)
                            $display("FAIL %s ReadDataW: got %h, required %h", name, ReadDataW, got.readData);
                        else passCnt++;
                    end
                end
            end
        end
        bus.dmem_ready = 1'b0;
        if (!done) begin
            checkCnt++;
            $display("FAIL %s retire: no retirement within 40 cycles, required one", name);
            void'(sb.pop_front());
        end
    endtask

    int          nStall, nReq;
    logic        isStable, fWe;
    logic [31:0] fAddr, fWdata;

    task automatic test_reset();
        checkCnt++;
        if ({RegWriteW, ResultSrcW, ALUresultW, ReadDataW, PCplus4W, RdW, bus_err} !== '0)
            $display("FAIL reset W outputs: rw=%b alu=%h rd=%h pc=%h rd=%0d err=%b, required all 0",
                     RegWriteW, ALUresultW, ReadDataW, PCplus4W, RdW, bus_err);
        else passCnt++;
        checkCnt++;
        if (bus.dmem_req !== 1'b0 || stallM !== 1'b0)
            $display("FAIL reset bus: req=%b stall=%b, required 0/0", bus.dmem_req, stallM);
        else passCnt++;
    endtask

    task automatic test_alu();
        runInstr("alu", 1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_1004, 5'd5, 0, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nReq !== 0 || nStall !== 0)
            $display("FAIL alu no-req: reqs=%0d stalls=%0d, required 0/0", nReq, nStall);
        else passCnt++;
    endtask

    task automatic test_load_zero_wait();
        runInstr("load0", 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_1008, 5'd7, 0, 32'hDEAD_BEEF,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nStall !== 0 || nReq !== 1 || fAddr !== 32'h100 || fWe !== 1'b0)
            $display("FAIL load0 bus: stalls=%0d reqs=%0d addr=%h we=%b, required 0/1/100/0",
                     nStall, nReq, fAddr, fWe);
        else passCnt++;
    endtask

    task automatic test_store_wait();
        runInstr("store3", 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'h0000_100C, 5'd9, 3, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nStall !== 3 || nReq !== 4)
            $display("FAIL store3 wait: stalls=%0d reqs=%0d, required 3/4", nStall, nReq);
        else passCnt++;
        checkCnt++;
        if (!isStable || fAddr !== 32'h200 || fWe !== 1'b1 || fWdata !== 32'h1234)
            $display("FAIL store3 bus: stable=%b addr=%h we=%b wdata=%h, required 1/200/1/1234",
                     isStable, fAddr, fWe, fWdata);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h0000_0011, 32'h0000_0104, 32'h0000_0108, 32'h0000_0033};
        logic        loads [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        stores[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            runInstr("b2b", 1'b1, loads[i], stores[i], addrs[i], 32'hA5A5_0000 + 32'(i),
                     32'h0000_2000 + 32'(4 * i), 5'(10 + i), 0, 32'hC0DE_0000 + 32'(i),
                     nStall, nReq, isStable, fAddr, fWe, fWdata);
            checkCnt++;
            if (nStall !== 0)
                $display("FAIL b2b throughput %0d: stalls=%0d, required 0", i, nStall);
            else passCnt++;
        end
    endtask

    task automatic test_timeout();
        checkCnt++;
        if (bus_err !== 1'b0)
            $display("FAIL timeout pre err: bus_err=%b, required 0", bus_err);
        else passCnt++;
        runInstr("timeout", 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_3000, 5'd12, -1, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nStall !== TIMEOUT - 1 || nReq !== TIMEOUT || !isStable)
            $display("FAIL timeout length: stalls=%0d reqs=%0d stable=%b, required %0d/%0d/1",
                     nStall, nReq, isStable, TIMEOUT - 1, TIMEOUT);
        else passCnt++;
        checkCnt++;
        if (bus_err !== 1'b1)
            $display("FAIL timeout err: bus_err=%b, required 1", bus_err);
        else passCnt++;
        runInstr("after_timeout", 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 32'h0000_3004, 5'd13, 0, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nReq !== 0)
            $display("FAIL timeout req drop: reqs=%0d, required 0", nReq);
        else passCnt++;
    endtask

    task automatic test_reset_midbusy();
        RegWriteM = 1'b1; ResultSrcM = 1'b1; MemwriteM = 1'b0; ALUresultM = 32'h0000_0300;
        RdM = 5'd3; PCplus4M = 32'h0000_4000;
        bus.dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkCnt++;
        if (stallM !== 1'b1 || bus.dmem_req !== 1'b1)
            $display("FAIL midbusy pre: stall=%b req=%b, required 1/1", stallM, bus.dmem_req);
        else passCnt++;
        rst = 1'b0;
        #1;
        checkCnt++;
        if (bus.dmem_req !== 1'b0 || stallM !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL midbusy reset bus: req=%b stall=%b err=%b, required 0/0/0",
                     bus.dmem_req, stallM, bus_err);
        else passCnt++;
        checkCnt++;
        if ({RegWriteW, ResultSrcW, ALUresultW, ReadDataW, PCplus4W, RdW} !== '0)
            $display("FAIL midbusy reset W: rw=%b alu=%h rdata=%h pc=%h rd=%0d, required all 0",
                     RegWriteW, ALUresultW, ReadDataW, PCplus4W, RdW);
        else passCnt++;
        RegWriteM = 1'b0; ResultSrcM = 1'b0; ALUresultM = '0; RdM = '0; PCplus4M = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned();
        checkCnt++;
        if (bus_err !== 1'b0)
            $display("FAIL misaligned pre err: bus_err=%b, required 0", bus_err);
        else passCnt++;
        runInstr("misaligned", 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_5000, 5'd8, 0, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
        checkCnt++;
        if (nReq !== 0 || nStall !== 0 || bus_err !== 1'b1)
            $display("FAIL misaligned: reqs=%0d stalls=%0d err=%b, required 0/0/1", nReq, nStall, bus_err);
        else passCnt++;
        runInstr("after_misaligned", 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h0000_5004, 5'd21, 0, 32'h0,
                 nStall, nReq, isStable, fAddr, fWe, fWdata);
    endtask

    initial begin
        rst = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        test_alu();
        test_load_zero_wait();
        test_store_wait();
        test_back_to_back();
        test_timeout();
        test_reset_midbusy();
        test_misaligned();
        checkCnt++;
        if (sb.size() != 0)
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        else passCnt++;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
